// File: rtl/contador_regressivo_if.sv
// Control/status bundle between the control-unit FSM (master) and the down-counter (slave).
// D/Q are N bits wide; the counter itself must be built with the same N.
interface contador_regressivo_if #(
   parameter int unsigned N = 4
);
   logic         iniciar;
   logic         parar;
   logic         recarga;
   logic         ent;
   logic [N-1:0] D;
   logic [N-1:0] Q;
   logic         ocupado;
   logic         fim;
   logic         rco;

   modport master (
      output iniciar,
      output parar,
      output recarga,
      output ent,
      output D,
      input  Q,
      input  ocupado,
      input  fim,
      input  rco
   );

   modport slave (
      input  iniciar,
      input  parar,
      input  recarga,
      input  ent,
      input  D,
      output Q,
      output ocupado,
      output fim,
      output rco
   );
endinterface

// File: rtl/contador_regressivo.sv
// Programmable down-counting timer: loads D, steps down once every DIV enabled clocks,
// pulses fim for one cycle on expiry, with optional auto-reload and a borrow output.
module contador_regressivo #(
   parameter int unsigned N   = 4,
   parameter int unsigned DIV = 4
) (
   input logic                  clock,
   input logic                  clr,
   contador_regressivo_if.slave bus
);

   // Prescaler needs at least one bit even when DIV == 1.
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   typedef enum logic [1:0] {StIdle, StConta, StFim} estado_t;

   estado_t      state_q, state_d;
   logic [N-1:0] q_q, q_d;
   logic [PW-1:0] p_q, p_d;

   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         state_q <= StIdle;
         q_q     <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         p_q     <= p_d;
      end
   end

   // Priority: parar, then iniciar, then per-state behaviour.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      p_d     = p_q;

      if (bus.parar) begin
         state_d = StIdle;
         q_d     = '0;
         p_d     = '0;
      end else if (bus.iniciar) begin
         q_d     = bus.D;
         p_d     = '0;
         state_d = (bus.D != '0) ? StConta : StFim;
      end else begin
         unique case (state_q)
            StIdle: begin
            end

            StConta: begin
               if (bus.ent) begin
                  if (p_q != PMAX) begin
                     p_d = p_q + PW'(1);
                  end else begin
                     p_d = '0;
                     // Q is never 0 in StConta; the guard keeps a stray state from wrapping.
                     if (q_q != '0) begin
                        q_d = q_q - N'(1);
                     end
                     if (q_q == N'(1)) begin
                        state_d = StFim;
                     end
                  end
               end
            end

            StFim: begin
               if (bus.recarga) begin
                  if (bus.D != '0) begin
                     q_d     = bus.D;
                     p_d     = '0;
                     state_d = StConta;
                  end else begin
                     state_d = StFim;
                  end
               end else begin
                  state_d = StIdle;
               end
            end

            default: begin
               state_d = StIdle;
               q_d     = '0;
               p_d     = '0;
            end
         endcase
      end
   end

   assign bus.Q       = q_q;
   assign bus.ocupado = (state_q == StConta) || (state_q == StFim);
   assign bus.fim     = (state_q == StFim);
   assign bus.rco     = bus.ent && (q_q == '0);

endmodule

// File: tb/tb_contador_regressivo.sv
// Directed bench for contador_regressivo (N=4, DIV=4): a table of per-step vectors plus
// hand-written sequences for reset behaviour.
module tb_contador_regressivo;

   logic clock;
   logic clr;

   contador_regressivo_if #(.N(4)) bus ();

   contador_regressivo #(
      .N  (4),
      .DIV(4)
   ) dut (
      .clock(clock),
      .clr  (clr),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic       ini;
      logic       par;
      logic       rec;
      logic       ent;
      logic [3:0] d;
      int         n;      // clock edges to apply before checking
      logic [3:0] q;
      logic       oc;
      logic       fim;
      logic       rco;
   } vec_t;

   vec_t vecs[$];
   int   n_pass;
   int   n_total;

   task automatic add(input string name, input logic ini, input logic par, input logic rec,
                      input logic ent, input logic [3:0] d, input int n, input logic [3:0] q,
                      input logic oc, input logic fim, input logic rco);
      vec_t v;
      v.name = name; v.ini = ini; v.par = par; v.rec = rec; v.ent = ent; v.d = d; v.n = n;
      v.q = q; v.oc = oc; v.fim = fim; v.rco = rco;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] q, input logic oc,
                        input logic fim, input logic rco);
      n_total++;
      if ({bus.Q, bus.ocupado, bus.fim, bus.rco} === {q, oc, fim, rco}) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got Q=%0d ocupado=%b fim=%b rco=%b, want Q=%0d ocupado=%b fim=%b rco=%b",
                  name, bus.Q, bus.ocupado, bus.fim, bus.rco, q, oc, fim, rco);
      end
   endtask

   task automatic drive(input logic ini, input logic par, input logic rec, input logic ent,
                        input logic [3:0] d);
      bus.iniciar = ini;
      bus.parar   = par;
      bus.recarga = rec;
      bus.ent     = ent;
      bus.D       = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass  = 0;
      n_total = 0;

      // Basic count, D=3
      add("basic_load", 1, 0, 0, 1, 3, 1, 3, 1, 0, 0);
      add("basic_e3",   0, 0, 0, 1, 3, 3, 3, 1, 0, 0);
      add("basic_e4",   0, 0, 0, 1, 3, 1, 2, 1, 0, 0);
      add("basic_e7",   0, 0, 0, 1, 3, 3, 2, 1, 0, 0);
      add("basic_e8",   0, 0, 0, 1, 3, 1, 1, 1, 0, 0);
      add("basic_e11",  0, 0, 0, 1, 3, 3, 1, 1, 0, 0);
      add("basic_fim",  0, 0, 0, 1, 3, 1, 0, 1, 1, 1);
      add("basic_idle", 0, 0, 0, 1, 3, 1, 0, 0, 0, 1);
      add("idle_ent0",  0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      // Enable gating: 5 disabled cycles push fim from e12 to e17
      add("gate_load",  1, 0, 0, 1, 3, 1, 3, 1, 0, 0);
      add("gate_e5",    0, 0, 0, 1, 3, 5, 2, 1, 0, 0);
      add("gate_hold",  0, 0, 0, 0, 3, 5, 2, 1, 0, 0);
      add("gate_e12",   0, 0, 0, 1, 3, 2, 2, 1, 0, 0);
      add("gate_e13",   0, 0, 0, 1, 3, 1, 1, 1, 0, 0);
      add("gate_e16",   0, 0, 0, 1, 3, 3, 1, 1, 0, 0);
      add("gate_fim",   0, 0, 0, 1, 3, 1, 0, 1, 1, 1);
      add("gate_idle",  0, 0, 0, 1, 3, 1, 0, 0, 0, 1);
      // Auto-reload, D=2: fim period 9
      add("rl_load",    1, 0, 1, 1, 2, 1, 2, 1, 0, 0);
      add("rl_e7",      0, 0, 1, 1, 2, 7, 1, 1, 0, 0);
      add("rl_fim1",    0, 0, 1, 1, 2, 1, 0, 1, 1, 1);
      add("rl_reload1", 0, 0, 1, 1, 2, 1, 2, 1, 0, 0);
      add("rl_e16",     0, 0, 1, 1, 2, 7, 1, 1, 0, 0);
      add("rl_fim2",    0, 0, 1, 1, 2, 1, 0, 1, 1, 1);
      add("rl_reload2", 0, 0, 1, 1, 2, 1, 2, 1, 0, 0);
      add("rl_e25",     0, 0, 1, 1, 2, 7, 1, 1, 0, 0);
      add("rl_fim3",    0, 0, 1, 1, 2, 1, 0, 1, 1, 1);
      add("rl_stop",    0, 0, 0, 1, 2, 1, 0, 0, 0, 1);
      // Abort and restart, D=9
      add("ab_load",    1, 0, 0, 1, 9, 1, 9, 1, 0, 0);
      add("ab_e15",     0, 0, 0, 1, 9, 15, 6, 1, 0, 0);
      add("ab_q5",      0, 0, 0, 1, 9, 1, 5, 1, 0, 0);
      add("ab_parar",   0, 1, 0, 1, 9, 1, 0, 0, 0, 1);
      add("ab_nofim",   0, 0, 0, 1, 9, 3, 0, 0, 0, 1);
      add("ab_both",    1, 1, 0, 1, 9, 1, 0, 0, 0, 1);
      add("ab_reload",  1, 0, 0, 1, 9, 1, 9, 1, 0, 0);
      add("ab_q4",      0, 0, 0, 1, 9, 20, 4, 1, 0, 0);
      add("ab_restart", 1, 0, 0, 1, 6, 1, 6, 1, 0, 0);
      add("ab_r3",      0, 0, 0, 1, 6, 3, 6, 1, 0, 0);
      add("ab_r4",      0, 0, 0, 1, 6, 1, 5, 1, 0, 0);
      add("ab_stop",    0, 1, 0, 1, 6, 1, 0, 0, 0, 1);
      // Boundaries: D=0 and D=15
      add("d0_fim",     1, 0, 0, 1, 0, 1, 0, 1, 1, 1);
      add("d0_idle",    0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
      add("d0_rl",      1, 0, 1, 1, 0, 1, 0, 1, 1, 1);
      add("d0_rl_hold", 0, 0, 1, 1, 0, 2, 0, 1, 1, 1);
      add("d0_rl_end",  0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
      add("d15_load",   1, 0, 0, 1, 15, 1, 15, 1, 0, 0);
      add("d15_e59",    0, 0, 0, 1, 15, 59, 1, 1, 0, 0);
      add("d15_fim",    0, 0, 0, 1, 15, 1, 0, 1, 1, 1);
      add("d15_idle",   0, 0, 0, 1, 15, 1, 0, 0, 0, 1);

      // Reset state, including rco following ent while Q=0
      clr = 1'b0;
      drive(0, 0, 0, 0, 4'd0);
      #3;
      check("reset_ent0", 4'd0, 0, 0, 0);
      bus.ent = 1'b1;
      #1;
      check("reset_ent1", 4'd0, 0, 0, 1);
      bus.ent = 1'b0;
      @(negedge clock);
      clr = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("post_reset_idle", 4'd0, 0, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clock);
         drive(vecs[i].ini, vecs[i].par, vecs[i].rec, vecs[i].ent, vecs[i].d);
         repeat (vecs[i].n) @(posedge clock);
         #1;
         check(vecs[i].name, vecs[i].q, vecs[i].oc, vecs[i].fim, vecs[i].rco);
      end

      // Asynchronous reset mid-count, between clock edges
      @(negedge clock);
      drive(1, 0, 0, 1, 4'd9);
      @(posedge clock);
      @(negedge clock);
      drive(0, 0, 0, 1, 4'd9);
      repeat (6) @(posedge clock);
      #1;
      check("ar_before", 4'd8, 1, 0, 0);
      #2;
      clr = 1'b0;
      #1;
      check("ar_immediate", 4'd0, 0, 0, 1);
      @(posedge clock);
      #1;
      check("ar_held", 4'd0, 0, 0, 1);
      @(negedge clock);
      clr = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("ar_stays_idle", 4'd0, 0, 0, 1);
      @(negedge clock);
      drive(1, 0, 0, 1, 4'd5);
      @(posedge clock);
      #1;
      check("ar_restart", 4'd5, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/contador_regressivo.md
# contador_regressivo

Programmable down-counting timer that counts in the opposite direction to the team's up counters. It loads a start value, decrements once every `DIV` enabled clocks, and signals completion with a one-cycle `fim` pulse. It provides a borrow output (`rco`) for cascading and an optional auto-reload mode. It sits in the drone datapath next to the up counters and is driven by the control-unit FSM for timed phases (hold times, timeouts).

## Interface
- `N`, default 4: counter width in bits.
- `DIV`, default 4: enabled clock cycles per decrement step; legal range is 1 or more. `DIV=1` means one decrement per enabled clock.
- `clock`: input, 1 bit. Rising-edge clock.
- `clr`: input, 1 bit. Reset, asynchronous, active-low.
- `iniciar`: input, 1 bit. Start or restart; loads `D`.
- `parar`: input, 1 bit. Abort; returns the block to idle.
- `recarga`: input, 1 bit. Auto-reload enable, sampled in state FIM.
- `ent`: input, 1 bit. Count enable; also gates `rco`.
- `D`: input, N bits. Start value.
- `Q`: output, N bits. Current count, registered.
- `ocupado`: output, 1 bit. High in states CONTA and FIM (Moore).
- `fim`: output, 1 bit. High only in state FIM (Moore); one cycle per expiry.
- `rco`: output, 1 bit. Borrow, combinational: `ent && (Q == 0)`.

## Operation
- States: IDLE, CONTA, FIM. There is an internal prescaler `p` of width clog2(DIV), minimum 1 bit.
- Reset (`clr=0`, asynchronous) sets:
  - state IDLE, `Q=0`, `p=0`;
  - `ocupado=0`, `fim=0`;
  - `rco` equals `ent`, because `Q=0`.
- Priority at every clock edge: `parar` first, then `iniciar`, then state behaviour.
- `parar=1` in any state: next state IDLE, `Q<=0`, `p<=0`. No `fim` pulse is produced.
- `iniciar=1` in any state (with `parar=0`): `Q<=D`, `p<=0`.
  - Next state is CONTA if `D!=0`.
  - Next state is FIM if `D==0`, which gives an immediate expiry.
  - In CONTA this restarts the count and discards any progress.
- IDLE: `Q` holds. No other activity.
- CONTA with `ent=0`: `Q` and `p` freeze.
- CONTA with `ent=1`:
  - If `p != DIV-1`: `p<=p+1`.
  - Otherwise: `p<=0` and `Q<=Q-1`. If `Q==1` at that edge, the next state is FIM with `Q` becoming 0.
- FIM: lasts exactly one cycle; `fim=1` during it. `Q=0` unless `iniciar` reloads it.
  - If `recarga=1` and `D!=0`: `Q<=D`, `p<=0`, next state CONTA.
  - If `recarga=1` and `D==0`: next state FIM again, so `fim` stays high while the condition persists.
  - If `recarga=0`: next state IDLE.
- Arithmetic is unsigned and modulo 2^N.
  - Underflow cannot occur from counting, because CONTA never decrements at `Q==0`.
  - All N bits of `D` are used. `D = 2^N-1` is legal.

## Timing
- `iniciar` is sampled at edge e0. From the cycle after e0, `Q=D` and `ocupado=1`.
- With `ent` held at 1 and `D=k>0`:
  - `Q` decrements at edges e0+DIV, e0+2·DIV, and so on.
  - State FIM, `fim=1` and `Q=0` occur in the cycle following edge e0+k·DIV.
  - `ocupado` falls one cycle later when `recarga=0`.
- Each cycle with `ent=0` during CONTA delays expiry by exactly one cycle.
- In auto-reload with `D=k`, the `fim` pulse period is k·DIV+1 cycles, because FIM consumes one cycle.
- `rco` is combinational from `Q` and `ent`, with no added latency.
- `clr` takes effect immediately, without waiting for a clock, and overrides everything.

## Test plan
- **Basic count** (N=4, DIV=4), `D=3`, one-cycle `iniciar`, `ent=1`, `recarga=0`:
  - `Q` steps 3, 2, 1, 0 at edges +4, +8, +12.
  - `fim=1` for exactly 1 cycle, then `ocupado=0` and `Q=0`.
- **Enable gating**: same as the basic count, with `ent=0` for 5 cycles mid-count.
  - `fim` arrives exactly 5 cycles later than in the basic count.
  - `rco` stays 0 until `Q=0` with `ent=1`.
- **Auto-reload**, `D=2`, `recarga=1`:
  - `fim` pulses every 9 cycles, at least 3 times.
  - `Q` reloads to 2 in the cycle after each pulse.
- **Abort and restart**, `D=9`:
  - `parar` asserted at `Q=5` gives IDLE, `Q=0` and no `fim`.
  - `iniciar` and `parar` asserted in the same cycle gives IDLE.
  - `iniciar` asserted at `Q=4` with `D=6` gives `Q=6` and a restarted count.
- **Boundaries**:
  - `D=0` with `iniciar` gives `fim` in the next cycle with no CONTA.
  - `D=15` gives `fim` after 60 enabled cycles.
- **Async reset**: `clr=0` asserted mid-count between clock edges.
  - `Q=0`, `fim=0` and `ocupado=0` take effect immediately.
  - After release, the block stays in IDLE until `iniciar`.
